// File: rtl/clksel_pkg.sv
// clksel_pkg: state type, default parameters and counter-width helper for clksel_ctrl
package clksel_pkg;
  typedef enum logic [2:0] {INIT, RUN, GATE, SWITCH, SETTLE} clksel_state_t;
  localparam int WINDOW_DEF = 1024;
  localparam int MIN_EDGES_DEF = 4;
  localparam int GATE_CYCLES_DEF = 4;
  localparam int HOLD_WINDOWS_DEF = 2;
  function automatic int cnt_w(input int max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction
endpackage

// File: rtl/clk_edge_counter.sv
// clk_edge_counter: synchronizes a sampled clock and counts its rising edges, saturating at MAX
module clk_edge_counter
  import clksel_pkg::*;
#(
  parameter int MAX = MIN_EDGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic clr,
  output logic full
);
  localparam int W = cnt_w(MAX);
  logic [2:0] sync;
  logic [W-1:0] cnt, cnt_nxt;
  logic rise;
  assign rise = sync[1] & ~sync[2];
  // includes this cycle's edge so an edge on the window-closing cycle is not lost
  assign cnt_nxt = (cnt == W'(MAX)) ? cnt : cnt + W'(rise);
  assign full = cnt_nxt == W'(MAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      cnt <= '0;
    end else begin
      sync <= {sync[1:0], src};
      cnt <= clr ? '0 : cnt_nxt;
    end
endmodule

// File: rtl/clksel_ctrl.sv
// clksel_ctrl: clock-source supervisor driving mux select and glitch-free gate enable
// CLKSEL_AUTOREVERT_EN: return to the preferred source after HOLD_WINDOWS good windows
module clksel_ctrl
  import clksel_pkg::*;
#(
  parameter int WINDOW       = WINDOW_DEF,
  parameter int MIN_EDGES    = MIN_EDGES_DEF,
  parameter int GATE_CYCLES  = GATE_CYCLES_DEF,
  parameter int HOLD_WINDOWS = HOLD_WINDOWS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_a,
  input  logic clk_b,
  input  logic prefer_b,
  output logic sel,
  output logic clk_en,
  output logic a_ok,
  output logic b_ok,
  output logic busy
);
  localparam int WW = cnt_w(WINDOW - 1);
  localparam int GW = cnt_w(GATE_CYCLES);
  if (WINDOW < 16 || MIN_EDGES < 1 || 2 * MIN_EDGES >= WINDOW || GATE_CYCLES < 1 || HOLD_WINDOWS < 1)
    $error("clksel_ctrl: illegal parameter set");
  clksel_state_t state, nxt;
  logic [WW-1:0] win;
  logic [GW-1:0] gcnt;
  logic a_full, b_full, wend, wend_q, dec, pref_ok, cur_ok, oth_ok, rev, tgt, gdone;
  assign wend = win == WW'(WINDOW - 1);
  assign gdone = gcnt == GW'(GATE_CYCLES - 1);
  clk_edge_counter #(.MAX(MIN_EDGES)) u_a (.clk(clk), .rst_n(rst_n), .src(clk_a), .clr(wend), .full(a_full));
  clk_edge_counter #(.MAX(MIN_EDGES)) u_b (.clk(clk), .rst_n(rst_n), .src(clk_b), .clr(wend), .full(b_full));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win <= '0;
      a_ok <= 1'b0;
      b_ok <= 1'b0;
      wend_q <= 1'b0;
      dec <= 1'b0;
    end else begin
      win <= wend ? '0 : win + WW'(1);
      if (wend) begin
        a_ok <= a_full;
        b_ok <= b_full;
      end
      wend_q <= wend;
      dec <= wend_q;
    end
  assign pref_ok = prefer_b ? b_ok : a_ok;
  assign cur_ok = sel ? b_ok : a_ok;
  assign oth_ok = sel ? a_ok : b_ok;
  assign tgt = (pref_ok && rev) ? prefer_b : (cur_ok || !oth_ok) ? sel : ~sel;
`ifdef CLKSEL_AUTOREVERT_EN
  localparam int HW = cnt_w(HOLD_WINDOWS);
  logic [HW-1:0] hold;
  logic pref_full;
  assign pref_full = prefer_b ? b_full : a_full;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hold <= '0;
    else if (wend) hold <= !pref_full ? '0 : (hold == HW'(HOLD_WINDOWS)) ? hold : hold + HW'(1);
  assign rev = hold == HW'(HOLD_WINDOWS);
`else
  logic pref_q, pchg;
  // a preference change stays pending until a decision consumes it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pref_q <= 1'b0;
      pchg <= 1'b0;
    end else begin
      pref_q <= prefer_b;
      pchg <= (prefer_b != pref_q) | (pchg & ~dec);
    end
  assign rev = ~cur_ok | pchg;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      gcnt <= '0;
      sel <= 1'b0;
    end else begin
      state <= nxt;
      gcnt <= (nxt != state) ? '0 : gcnt + GW'(1);
      if (nxt == SWITCH && state != SWITCH) sel <= ~sel;
    end
  always_comb begin
    nxt = state;
    case (state)
      INIT:    if (dec && (a_ok || b_ok)) nxt = (tgt != sel) ? SWITCH : SETTLE;
      RUN:     if (dec && tgt != sel) nxt = GATE;
      GATE:    if (gdone) nxt = SWITCH;
      SWITCH:  nxt = SETTLE;
      SETTLE:  if (gdone) nxt = RUN;
      default: nxt = INIT;
    endcase
  end
  always_comb begin
    clk_en = state == RUN;
    busy = state != RUN;
  end
endmodule

// File: tb/tb_clksel_ctrl.sv
// tb_clksel_ctrl: directed self-checking bench for clksel_ctrl (WINDOW=64, GATE_CYCLES=4)
module tb_clksel_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, clk_a = 1'b0, clk_b = 1'b0, prefer_b = 1'b0;
  logic run_a = 1'b1, run_b = 1'b1, exp_sel;
  logic sel, clk_en, a_ok, b_ok, busy;
  int cyc = 0, n_pass = 0, n_tot = 0;
  clksel_ctrl #(.WINDOW(64), .MIN_EDGES(4), .GATE_CYCLES(4), .HOLD_WINDOWS(2)) dut (
    .clk(clk), .rst_n(rst_n), .clk_a(clk_a), .clk_b(clk_b), .prefer_b(prefer_b),
    .sel(sel), .clk_en(clk_en), .a_ok(a_ok), .b_ok(b_ok), .busy(busy)
  );
  always #5 clk = ~clk;
  always #40 clk_a = run_a & ~clk_a;
  initial begin
    #13;
    forever #40 clk_b = run_b & ~clk_b;
  end
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic check(input string tag, input logic obs, input logic exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
  endtask
  task automatic to_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic restart();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", sel, 1'b0);
    check("rst_clk_en", clk_en, 1'b0);
    check("rst_a_ok", a_ok, 1'b0);
    check("rst_b_ok", b_ok, 1'b0);
    check("rst_busy", busy, 1'b1);
    rst_n = 1'b1;
    to_cyc(63); check("a_ok_before_wend", a_ok, 1'b0);
    to_cyc(64); check("a_ok_first", a_ok, 1'b1); check("b_ok_first", b_ok, 1'b1);
    to_cyc(69); check("clk_en_c69", clk_en, 1'b0); check("busy_c69", busy, 1'b1);
    to_cyc(70); check("clk_en_c70", clk_en, 1'b1); check("busy_c70", busy, 1'b0); check("sel_c70", sel, 1'b0);
    run_a = 1'b0;
    to_cyc(127); check("a_ok_last_good", a_ok, 1'b1);
    to_cyc(128); check("a_ok_bad", a_ok, 1'b0); check("b_ok_good", b_ok, 1'b1);
    to_cyc(129); check("fo_clk_en_D", clk_en, 1'b1);
    to_cyc(130); check("fo_clk_en_D1", clk_en, 1'b0); check("fo_busy", busy, 1'b1); check("fo_sel_D1", sel, 1'b0);
    to_cyc(133); check("fo_sel_D4", sel, 1'b0);
    to_cyc(134); check("fo_sel_D5", sel, 1'b1); check("fo_clk_en_D5", clk_en, 1'b0);
    to_cyc(138); check("fo_clk_en_D9", clk_en, 1'b0);
    to_cyc(139); check("fo_clk_en_D10", clk_en, 1'b1); check("fo_busy_done", busy, 1'b0);
    to_cyc(140); run_a = 1'b1;
    to_cyc(192); check("a_ok_restored", a_ok, 1'b1);
`ifdef CLKSEL_AUTOREVERT_EN
    to_cyc(200); check("rv_sel_one_window", sel, 1'b1);
    to_cyc(258); check("rv_clk_en_low", clk_en, 1'b0);
    to_cyc(261); check("rv_sel_before", sel, 1'b1);
    to_cyc(262); check("rv_sel_back", sel, 1'b0); check("rv_clk_en_sw", clk_en, 1'b0);
    to_cyc(267); check("rv_clk_en_high", clk_en, 1'b1);
    exp_sel = 1'b0;
`else
    to_cyc(262); check("nr_sel_stays", sel, 1'b1); check("nr_clk_en", clk_en, 1'b1);
    to_cyc(300); check("nr_sel_later", sel, 1'b1);
    exp_sel = 1'b1;
`endif
    to_cyc(320); run_a = 1'b0; run_b = 1'b0;
    to_cyc(383); check("dead_a_prev", a_ok, 1'b1); check("dead_b_prev", b_ok, 1'b1);
    to_cyc(384); check("dead_a_ok", a_ok, 1'b0); check("dead_b_ok", b_ok, 1'b0);
    to_cyc(386); check("dead_sel", sel, exp_sel); check("dead_clk_en", clk_en, 1'b1); check("dead_busy", busy, 1'b0);
    to_cyc(400); check("dead_sel_late", sel, exp_sel); check("dead_clk_en_late", clk_en, 1'b1);
    run_a = 1'b1; run_b = 1'b1; rst_n = 1'b0;
    #1;
    check("rst2_sel", sel, 1'b0); check("rst2_clk_en", clk_en, 1'b0); check("rst2_busy", busy, 1'b1); check("rst2_b_ok", b_ok, 1'b0);
    restart();
    to_cyc(69); check("st2_clk_en_c69", clk_en, 1'b0);
    to_cyc(70); check("st2_clk_en_c70", clk_en, 1'b1); check("st2_sel", sel, 1'b0);
    to_cyc(80); prefer_b = 1'b1;
    to_cyc(129); check("pf_clk_en_D", clk_en, 1'b1); check("pf_sel_D", sel, 1'b0);
    to_cyc(130); check("pf_clk_en_D1", clk_en, 1'b0); check("pf_busy", busy, 1'b1);
    to_cyc(131); prefer_b = 1'b0;
    to_cyc(133); check("pf_sel_D4", sel, 1'b0);
    to_cyc(134); check("pf_sel_D5", sel, 1'b1); check("pf_clk_en_D5", clk_en, 1'b0);
    to_cyc(138); check("pf_clk_en_D9", clk_en, 1'b0);
    to_cyc(139); check("pf_clk_en_D10", clk_en, 1'b1);
    to_cyc(150); check("pf_gate_toggle_ignored", sel, 1'b1);
    to_cyc(193); check("pf2_sel_D", sel, 1'b1); check("pf2_clk_en_D", clk_en, 1'b1);
    to_cyc(194); check("pf2_clk_en_D1", clk_en, 1'b0);
    to_cyc(197); check("pf2_sel_D4", sel, 1'b1);
    to_cyc(198); check("pf2_sel_D5", sel, 1'b0);
    to_cyc(210); prefer_b = 1'b1;
    to_cyc(262); check("pf3_sel", sel, 1'b1); check("pf3_busy", busy, 1'b1);
    to_cyc(264); check("pf3_settle_clk_en", clk_en, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst3_sel", sel, 1'b0); check("rst3_clk_en", clk_en, 1'b0); check("rst3_busy", busy, 1'b1); check("rst3_a_ok", a_ok, 1'b0);
    prefer_b = 1'b0;
    restart();
    to_cyc(69); check("st3_clk_en_c69", clk_en, 1'b0);
    to_cyc(70); check("st3_clk_en_c70", clk_en, 1'b1); check("st3_sel", sel, 1'b0); check("st3_busy", busy, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
